// File: rtl/dso_pkg.sv
// Shared types and defaults for the scope datapath: dump sequencer state
// encoding, sample-RAM geometry and channel-select codes.
package dso_pkg;

    localparam int unsigned DEPTH_DEF = 512;
    localparam int unsigned AW_DEF    = 9;

    localparam logic [1:0] CH1     = 2'b00;
    localparam logic [1:0] CH2     = 2'b01;
    localparam logic [1:0] CH3     = 2'b10;
    localparam logic [1:0] CH_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_SEND,
        ST_WAIT_TX,
        ST_FIN
    } dump_state_t;

endpackage

// File: rtl/dump_sequencer.sv
// Streams one channel's circular sample RAM, oldest sample first, to the
// UART transmitter one byte at a time, then pulses dump_fin.
module dump_sequencer
    import dso_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump,
    input  logic [1:0]    ch_sel,
    input  logic [AW-1:0] trace_end,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    rdata_ch1,
    input  logic [7:0]    rdata_ch2,
    input  logic [7:0]    rdata_ch3,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_done,
    output logic          busy,
    output logic          dump_fin
);

    localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);

    dump_state_t   state;
    dump_state_t   state_nxt;
    logic [1:0]    ch_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] byte_cnt;
    logic [7:0]    rd_sel;
    logic          start;
    logic          last_byte;
    logic          advance;

    assign start     = (state == ST_IDLE) && dump && (ch_sel != CH_RSVD);
    assign last_byte = (byte_cnt == LAST_CNT);
    assign advance   = (state == ST_WAIT_TX) && tx_done && !last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_RD;
            ST_RD:      state_nxt = ST_LAT;
            ST_LAT:     state_nxt = ST_SEND;
            ST_SEND:    state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_done) state_nxt = last_byte ? ST_FIN : ST_RD;
            ST_FIN:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_addr = '0;
        tx_start = 1'b0;
        busy     = 1'b1;
        dump_fin = 1'b0;
        case (state)
            ST_IDLE: busy = 1'b0;
            ST_RD: begin
                ram_en   = 1'b1;
                ram_addr = rd_ptr;
            end
            ST_SEND: tx_start = 1'b1;
            ST_FIN:  dump_fin = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (ch_q)
            CH1:     rd_sel = rdata_ch1;
            CH2:     rd_sel = rdata_ch2;
            default: rd_sel = rdata_ch3;
        endcase
    end

    // Oldest sample sits just past the newest one; the pointer wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q     <= CH1;
            rd_ptr   <= '0;
            byte_cnt <= '0;
            tx_data  <= '0;
        end else begin
            if (start) begin
                ch_q     <= ch_sel;
                rd_ptr   <= trace_end + AW'(1);
                byte_cnt <= '0;
            end else if (advance) begin
                rd_ptr   <= rd_ptr + AW'(1);
                byte_cnt <= byte_cnt + AW'(1);
            end
            if (state == ST_LAT) begin
                tx_data <= rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: RAM and UART transmitter models,
// table-driven and random dumps, and hand-written corner-case sequences.
module tb_dump_sequencer;

    localparam int N = 512;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dump;
    logic [1:0] ch_sel;
    logic [8:0] trace_end;
    logic       ram_en;
    logic [8:0] ram_addr;
    logic [7:0] rdata_ch1, rdata_ch2, rdata_ch3;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic       busy;
    logic       dump_fin;

    dump_sequencer #(.DEPTH(512), .AW(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dump      (dump),
        .ch_sel    (ch_sel),
        .trace_end (trace_end),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .rdata_ch1 (rdata_ch1),
        .rdata_ch2 (rdata_ch2),
        .rdata_ch3 (rdata_ch3),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .busy      (busy),
        .dump_fin  (dump_fin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mem [3][N];

    int         addr_q[$];
    logic [7:0] byte_q[$];
    int         start_q[$];
    int         first_en_cyc = -1;
    int         fin_cnt = 0;
    int         fin_cyc = -1;

    int tx_delay = 1;
    bit spur = 0;
    int tx_cnt = 0;
    int last_done_cyc = -1;

    typedef struct {
        logic [1:0] ch;
        int         te;
        int         delay;
        bit         spur;
        bit         redump;
        int         exp_first;
        int         exp_last;
        string      tag;
    } vec_t;

    vec_t vecs[4];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (ram_en) begin
            rdata_ch1 <= mem[0][ram_addr];
            rdata_ch2 <= mem[1][ram_addr];
            rdata_ch3 <= mem[2][ram_addr];
        end
    end

    // Transmitter: tx_done lands tx_delay cycles after the tx_start cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_cnt  = 0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_cnt > 0) begin
                if (tx_cnt == 1) begin
                    tx_done       = 1'b1;
                    last_done_cyc = cyc;
                end
                tx_cnt--;
            end
            if (tx_start) tx_cnt = tx_delay;
            if (spur && (ram_en || tx_start)) tx_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (ram_en) begin
            addr_q.push_back(int'(ram_addr));
            if (addr_q.size() == 1) first_en_cyc = cyc;
        end
        if (tx_start) begin
            byte_q.push_back(tx_data);
            start_q.push_back(cyc);
        end
        if (dump_fin) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int ch, input int te, input int i);
        return mem[ch][(te + 1 + i) % N];
    endfunction

    task automatic clear_monitors();
        addr_q.delete();
        byte_q.delete();
        start_q.delete();
        first_en_cyc = -1;
    endtask

    task automatic run_dump(input logic [1:0] ch, input int te, input int delay,
                            input bit sp, input bit rd, input int ef, input int el,
                            input string tag);
        int fin0;
        int start_cyc;
        int budget;
        int nbad;
        int te_v;
        bit done;
        tx_delay = delay;
        tick();
        clear_monitors();
        fin0      = fin_cnt;
        te_v      = te;
        ch_sel    = ch;
        trace_end = te_v[8:0];
        dump      = 1'b1;
        start_cyc = cyc;
        spur      = sp;
        budget    = N * (delay + 4) + 50;
        done      = 0;
        for (int n = 0; n < budget && !done; n++) begin
            tick();
            dump = 1'b0;
            if (fin_cnt != fin0) begin
                done = 1;
            end else if (rd && (n % 37) == 5) begin
                dump      = 1'b1;
                ch_sel    = (ch == 2'b00) ? 2'b10 : 2'b00;
                trace_end = 9'($urandom);
            end
        end
        spur = 0;
        check({tag, " fin_seen"}, done, 1);
        tick();
        check({tag, " busy_after_fin"}, busy, 0);
        check({tag, " fin_count"}, fin_cnt - fin0, 1);
        check({tag, " tx_start_count"}, byte_q.size(), N);
        check({tag, " ram_en_count"}, addr_q.size(), N);
        check({tag, " fin_after_last_done"}, fin_cyc, last_done_cyc + 1);
        check({tag, " ram_en_latency"}, first_en_cyc, start_cyc + 1);
        if (start_q.size() > 0) check({tag, " tx_start_latency"}, start_q[0], start_cyc + 3);
        if (addr_q.size() > 0) begin
            check({tag, " first_addr"}, addr_q[0], ef);
            check({tag, " last_addr"}, addr_q[addr_q.size() - 1], el);
        end
        nbad = 0;
        for (int i = 0; i < addr_q.size() && i < N; i++)
            if (addr_q[i] != (te + 1 + i) % N) nbad++;
        check({tag, " addr_sequence_errors"}, nbad, 0);
        nbad = 0;
        for (int i = 0; i < byte_q.size() && i < N; i++) begin
            if (byte_q[i] !== exp_byte(int'(ch), te, i)) begin
                if (nbad == 0)
                    $display("FAIL %s byte[%0d] actual=%0d expected=%0d", tag, i,
                             byte_q[i], exp_byte(int'(ch), te, i));
                nbad++;
            end
        end
        check({tag, " byte_stream_errors"}, nbad, 0);
        nbad = 0;
        for (int k = 1; k < start_q.size(); k++)
            if (start_q[k] - start_q[k - 1] != delay + 3) nbad++;
        check({tag, " tx_start_spacing_errors"}, nbad, 0);
    endtask

    initial begin
        int fin0;
        int te_r;
        int budget;
        bit seen_busy;
        logic [1:0] ch_r;

        for (int c = 0; c < 3; c++)
            for (int i = 0; i < N; i++)
                mem[c][i] = (c == 1) ? 8'(i) : 8'($urandom);

        vecs[0] = '{2'b01, 100, 10, 1'b0, 1'b0, 101, 100, "basic"};
        vecs[1] = '{2'b00, 511,  1, 1'b0, 1'b0,   0, 511, "wrap"};
        vecs[2] = '{2'b10,   0,  3, 1'b1, 1'b0,   1,   0, "spurious"};
        vecs[3] = '{2'b01, 300,  2, 1'b0, 1'b1, 301, 300, "redump"};

        rst_n     = 1'b0;
        dump      = 1'b0;
        ch_sel    = 2'b00;
        trace_end = '0;
        repeat (3) tick();
        check("reset_outputs", {ram_en, ram_addr, tx_data, tx_start, busy, dump_fin}, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[v])
            run_dump(vecs[v].ch, vecs[v].te, vecs[v].delay, vecs[v].spur, vecs[v].redump,
                     vecs[v].exp_first, vecs[v].exp_last, vecs[v].tag);

        for (int r = 0; r < 2; r++) begin
            ch_r = 2'($urandom_range(0, 2));
            te_r = int'($urandom_range(0, N - 1));
            run_dump(ch_r, te_r, int'($urandom_range(1, 4)), 1'b0, 1'b0,
                     (te_r + 1) % N, te_r, $sformatf("random%0d", r));
        end

        // Reserved channel select must not start a dump.
        tick();
        clear_monitors();
        ch_sel    = 2'b11;
        trace_end = 9'd7;
        dump      = 1'b1;
        seen_busy = 0;
        tick();
        dump = 1'b0;
        repeat (10) begin
            tick();
            if (busy) seen_busy = 1;
        end
        check("reserved busy_seen", seen_busy, 0);
        check("reserved ram_en_count", addr_q.size(), 0);

        // Reset in the middle of a dump abandons it without dump_fin.
        tx_delay = 1;
        tick();
        clear_monitors();
        fin0      = fin_cnt;
        ch_sel    = 2'b10;
        trace_end = 9'd50;
        dump      = 1'b1;
        tick();
        dump   = 1'b0;
        budget = 0;
        while (byte_q.size() < 201 && budget < 2000) begin
            tick();
            budget++;
        end
        check("midreset reached_byte_200", byte_q.size() >= 201, 1);
        rst_n = 1'b0;
        #1;
        check("midreset outputs_zero",
              {ram_en, ram_addr, tx_data, tx_start, busy, dump_fin}, 0);
        repeat (3) tick();
        check("midreset no_fin", fin_cnt - fin0, 0);
        rst_n = 1'b1;
        tick();
        check("midreset still_no_fin", fin_cnt - fin0, 0);
        run_dump(2'b10, 50, 1, 1'b0, 1'b0, 51, 50, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
